// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and segment patterns for the seven-segment scanner
package seg_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] bcd_t;

  // Segment order is {a,b,c,d,e,f,g}, active high.
  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;
  localparam seg_t SEG_DASH  = 7'b0000001;
  localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - combinational BCD to seven-segment decoder
module bcd_to_seg
  import seg_pkg::*;
(
  input  bcd_t bcd_i,
  output seg_t seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - multiplexed seven-segment driver with double-buffered digits
module seg_scan
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 1000,
  parameter int DIGITS  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic [4*DIGITS-1:0]        digits_in,
  input  logic [DIGITS-1:0]          dp_in,
  input  logic                       blank_lz,
  output logic [6:0]                 seg_out,
  output logic                       dp_out,
  output logic [DIGITS-1:0]          an_out,
  output logic [$clog2(DIGITS)-1:0]  digit_idx,
  output logic                       ack
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  bcd_t [DIGITS-1:0]       act_dig_q, act_dig_d;
  logic [DIGITS-1:0]       act_dp_q, act_dp_d;
  bcd_t [DIGITS-1:0]       sh_dig_q, sh_dig_d;
  logic [DIGITS-1:0]       sh_dp_q, sh_dp_d;
  logic                    pending_q, pending_d;
  logic                    xfer_q, xfer_d;

  seg_t                    seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [DIGITS-1:0]       an_q, an_d;
  logic [IDX_W-1:0]        didx_q;
  logic                    ack_q;

  logic                    tc;
  logic                    frame_end;
  bcd_t                    cur_dig;
  seg_t                    cur_seg;
  logic [DIGITS-1:0]       blank;
  logic                    run;

  assign tc        = (pre_q == PRE_LAST);
  assign frame_end = tc && (idx_q == IDX_LAST);
  assign cur_dig   = act_dig_q[idx_q];

  bcd_to_seg u_dec (
    .bcd_i (cur_dig),
    .seg_o (cur_seg)
  );

  always_comb begin
    pre_d     = tc ? '0 : pre_q + PRE_W'(1);
    idx_d     = idx_q;
    act_dig_d = act_dig_q;
    act_dp_d  = act_dp_q;
    sh_dig_d  = sh_dig_q;
    sh_dp_d   = sh_dp_q;
    pending_d = pending_q;
    xfer_d    = 1'b0;

    if (tc) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    if (load) begin
      sh_dig_d  = digits_in;
      sh_dp_d   = dp_in;
      pending_d = 1'b1;
    end

    // A load landing on the frame boundary bypasses the shadow so it is never a frame late.
    if (frame_end) begin
      if (load) begin
        act_dig_d = digits_in;
        act_dp_d  = dp_in;
        pending_d = 1'b0;
        xfer_d    = 1'b1;
      end else if (pending_q) begin
        act_dig_d = sh_dig_q;
        act_dp_d  = sh_dp_q;
        pending_d = 1'b0;
        xfer_d    = 1'b1;
      end
    end
  end

  // Blanking propagates downward from the top digit until a nonzero digit or a dp.
  always_comb begin
    blank = '0;
    run   = blank_lz;
    for (int i = DIGITS - 1; i > 0; i--) begin
      run      = run && (act_dig_q[i] == 4'd0) && !act_dp_q[i];
      blank[i] = run;
    end
  end

  always_comb begin
    seg_d        = blank[idx_q] ? SEG_BLANK : cur_seg;
    dp_d         = act_dp_q[idx_q] && !blank[idx_q];
    an_d         = '0;
    an_d[idx_q]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q     <= '0;
      idx_q     <= '0;
      act_dig_q <= '0;
      act_dp_q  <= '0;
      sh_dig_q  <= '0;
      sh_dp_q   <= '0;
      pending_q <= 1'b0;
      xfer_q    <= 1'b0;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b0;
      an_q      <= '0;
      didx_q    <= '0;
      ack_q     <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      act_dig_q <= act_dig_d;
      act_dp_q  <= act_dp_d;
      sh_dig_q  <= sh_dig_d;
      sh_dp_q   <= sh_dp_d;
      pending_q <= pending_d;
      xfer_q    <= xfer_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
      didx_q    <= idx_q;
      ack_q     <= xfer_q;
    end
  end

  assign seg_out   = seg_q;
  assign dp_out    = dp_q;
  assign an_out    = an_q;
  assign digit_idx = didx_q;
  assign ack       = ack_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - scoreboard bench for seg_scan with CLK_DIV=4
module tb_seg_scan;

  localparam int DIV = 4;

  localparam logic [6:0] Z    = 7'b1111110;
  localparam logic [6:0] S1   = 7'b0110000;
  localparam logic [6:0] S2   = 7'b1101101;
  localparam logic [6:0] S3   = 7'b1111001;
  localparam logic [6:0] S4   = 7'b0110011;
  localparam logic [6:0] S5   = 7'b1011011;
  localparam logic [6:0] S6   = 7'b1011111;
  localparam logic [6:0] S7   = 7'b1110000;
  localparam logic [6:0] S8   = 7'b1111111;
  localparam logic [6:0] DASH = 7'b0000001;
  localparam logic [6:0] BL   = 7'b0000000;

  typedef struct packed {
    logic [3:0] an;
    logic [1:0] idx;
    logic [6:0] seg;
    logic       dp;
    logic       ack;
  } obs_t;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic [1:0]  digit_idx;
  logic        ack;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   popped = 0;

  seg_scan #(.CLK_DIV(DIV), .DIGITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .digits_in (digits_in),
    .dp_in     (dp_in),
    .blank_lz  (blank_lz),
    .seg_out   (seg_out),
    .dp_out    (dp_out),
    .an_out    (an_out),
    .digit_idx (digit_idx),
    .ack       (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected entry per displayed cycle, popped on the falling edge.
  always @(negedge clk) begin
    if (rst_n && exp_q.size() != 0) begin
      obs_t e;
      obs_t a;
      e = exp_q.pop_front();
      a = '{an: an_out, idx: digit_idx, seg: seg_out, dp: dp_out, ack: ack};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL scan[%0d] got an=%b idx=%0d seg=%b dp=%b ack=%b want an=%b idx=%0d seg=%b dp=%b ack=%b",
                 popped, a.an, a.idx, a.seg, a.dp, a.ack, e.an, e.idx, e.seg, e.dp, e.ack);
      end
      popped++;
    end
  end

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] dp, input bit with_ack);
    logic [6:0] s [4];
    obs_t e;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < DIV; c++) begin
        e.an  = 4'b0001 << d;
        e.idx = d[1:0];
        e.seg = s[d];
        e.dp  = dp[d];
        e.ack = with_ack && (d == 0) && (c == 0);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
    load      = 1'b1;
    digits_in = d;
    dp_in     = dp;
    tick();
    load      = 1'b0;
  endtask

  task automatic check_reset(input string name);
    total++;
    if ({seg_out, dp_out, an_out, digit_idx, ack} !== 15'd0) begin
      bad++;
      $display("FAIL %s got seg=%b dp=%b an=%b idx=%0d ack=%b want all zero",
               name, seg_out, dp_out, an_out, digit_idx, ack);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    load      = 1'b0;
    digits_in = '0;
    dp_in     = '0;
    blank_lz  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_hold");

    push_frame(Z,  Z,    Z,  Z,  4'b0000, 1'b0);
    push_frame(S4, S3,   S2, S1, 4'b0000, 1'b1);
    push_frame(S4, S3,   S2, S1, 4'b0000, 1'b0);
    push_frame(Z,  S5,   BL, BL, 4'b0000, 1'b1);
    push_frame(Z,  S5,   Z,  BL, 4'b0100, 1'b1);
    push_frame(Z,  DASH, BL, BL, 4'b0000, 1'b1);
    push_frame(S2, S2,   S2, S2, 4'b0000, 1'b1);
    push_frame(S8, S7,   S6, S5, 4'b0000, 1'b1);
    push_frame(S8, S7,   S6, S5, 4'b0000, 1'b0);

    @(negedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;

    run_to(5);   do_load(16'h1234, 4'b0000);
    run_to(32);  blank_lz = 1'b1;
    run_to(39);  do_load(16'h0050, 4'b0000);
    run_to(55);  do_load(16'h0050, 4'b0100);
    run_to(71);  do_load(16'h00A0, 4'b0000);
    run_to(87);  do_load(16'h1111, 4'b0000);
    run_to(91);  do_load(16'h2222, 4'b0000);
    run_to(96);  blank_lz = 1'b0;
    run_to(111); do_load(16'h5678, 4'b0000);
    run_to(145); do_load(16'h9999, 4'b1111);
    run_to(150);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain1 got left=%0d want 0", exp_q.size());
    end

    rst_n = 1'b0;
    #1;
    check_reset("reset_mid");

    push_frame(Z, Z, Z, Z, 4'b0000, 1'b0);
    push_frame(Z, Z, Z, Z, 4'b0000, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 64) tick();

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain2 got left=%0d want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
